// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//
// Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on the same operands the ALU
// sees. Operands are reduced to magnitudes on an accepted start, processed
// one bit per cycle (shift-add multiply or restoring divide), and the sign is
// re-applied in a single fix-up cycle before the result is registered.
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous, active-high reset
//   start   request; sampled only in IDLE or DONE
//   funct3  operation select (RV32M encoding)
//   dataa   rs1 operand, captured on accepted start
//   datab   rs2 operand, captured on accepted start
//   busy    high while iterating or fixing up the sign (pipe stall)
//   done    one-cycle pulse when result is valid
//   result  registered result, held until overwritten
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MUL  = 3'b000;
    localparam logic [2:0] OP_MULH = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_REM  = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       count;
    logic [2:0]             op;
    logic                   neg;
    logic [WIDTH-1:0]       opa;   // multiplicand, or divisor for divides
    logic [2*WIDTH-1:0]     acc;   // product, or dividend/quotient in low half
    logic [WIDTH-1:0]       rem;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        // The most negative value maps onto itself, read as unsigned.
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v,
                                                     input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic n);
        return n ? -v : v;
    endfunction

    // Operand decode for the request currently on the inputs
    logic             is_div_in, a_signed_in, b_signed_in;
    logic             sa_in, sb_in, neg_in;
    logic             div_zero, div_ovf, special_in, accept;
    logic [WIDTH-1:0] mag_a, mag_b, special_res;

    assign is_div_in   = funct3[2];
    assign a_signed_in = (funct3 == OP_MUL) || (funct3 == OP_MULH) || (funct3 == 3'b010) ||
                         (funct3 == OP_DIV) || (funct3 == OP_REM);
    assign b_signed_in = (funct3 == OP_MUL) || (funct3 == OP_MULH) ||
                         (funct3 == OP_DIV) || (funct3 == OP_REM);
    assign sa_in       = a_signed_in & dataa[WIDTH-1];
    assign sb_in       = b_signed_in & datab[WIDTH-1];
    // A remainder takes the dividend's sign; everything else the XOR of both.
    assign neg_in      = (funct3 == OP_REM) ? sa_in : (sa_in ^ sb_in);
    assign mag_a       = magnitude(dataa, a_signed_in);
    assign mag_b       = magnitude(datab, b_signed_in);

    assign div_zero    = is_div_in && (datab == '0);
    assign div_ovf     = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                         (dataa == {1'b1, {(WIDTH-1){1'b0}}}) && (datab == '1);
    assign special_in  = div_zero || div_ovf;
    // funct3[1] distinguishes REM* from DIV*
    assign special_res = div_zero ? (funct3[1] ? dataa : '1)
                                  : (funct3[1] ? '0 : dataa);

    assign accept      = start && ((state == IDLE) || (state == DONE));

    // Iteration step logic
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             q_bit;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : '0)};
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opa};
    assign q_bit     = ~div_diff[WIDTH+1];

    // Sign fix-up and output select
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, sel_res;

    assign prod_fix = cond_neg2(acc, neg);
    assign quo_fix  = cond_neg(acc[WIDTH-1:0], neg);
    assign rem_fix  = cond_neg(rem, neg);

    always_comb begin
        sel_res = prod_fix[WIDTH-1:0];
        case (op)
            3'b000:                 sel_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: sel_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         sel_res = quo_fix;
            default:                sel_res = rem_fix;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = special_in ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (count == LAST_ITER) state_nxt = SIGN;
            end
            SIGN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = special_in ? DONE : CALC;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            op     <= '0;
            neg    <= 1'b0;
            opa    <= '0;
            acc    <= '0;
            rem    <= '0;
            result <= '0;
        end else if (accept) begin
            op    <= funct3;
            neg   <= neg_in;
            count <= '0;
            rem   <= '0;
            if (special_in) begin
                result <= special_res;
            end else if (is_div_in) begin
                opa <= mag_b;
                acc <= {{WIDTH{1'b0}}, mag_a};
            end else begin
                opa <= mag_a;
                acc <= {{WIDTH{1'b0}}, mag_b};
            end
        end else if (state == CALC) begin
            count <= count + 1'b1;
            if (op[2]) begin
                // Restoring divide: keep the trial subtraction only if it did not borrow.
                rem               <= q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                acc[WIDTH-1:0]    <= {acc[WIDTH-2:0], q_bit};
            end else begin
                // Shift-add: multiplier sits in the low half and is consumed LSB first.
                acc <= {mul_sum, acc[WIDTH-1:1]};
            end
        end else if (state == SIGN) begin
            result <= sel_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .dataa  (dataa),
        .datab  (datab),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives start for one cycle (cycle 0) at a negedge, then watches up to 40
    // cycles for done. Returns at the negedge of the done cycle, so a following
    // call issues its start in the DONE cycle (back-to-back). A nonzero poke
    // raises start with unrelated operands in that cycle while the unit is busy.
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_cyc, input int poke);
        int done_cyc;
        int busy_err;
        done_cyc = -1;
        busy_err = 0;
        funct3 = f;
        dataa  = a;
        datab  = b;
        start  = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            if (poke != 0 && c == poke) begin
                start  = 1'b1;
                funct3 = 3'b101;
                dataa  = 32'h0000_1234;
                datab  = 32'h0000_0005;
            end
            if (poke != 0 && c == poke + 1) start = 1'b0;
            if (c < exp_cyc && busy !== 1'b1) busy_err++;
            if (c == exp_cyc && busy !== 1'b0) busy_err++;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
        check({tag, "_busy_errs"}, 32'(busy_err), 32'd0);
        check({tag, "_result"}, result, exp);
    endtask

    initial begin
        int c10;
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'b000;
        dataa  = 32'h0;
        datab  = 32'h0;
        #2;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_done", {31'b0, done}, 32'd0);

        // Basic multiply from IDLE
        run_op("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
        // High-half multiplies, each started in the previous DONE cycle
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        // Divides
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 0);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 0);
        run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        34, 0);
        run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         34, 0);
        // Special divide cases finish in cycle 1 without busy
        run_op("div0",   3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("remu0",  3'b111, 32'd5,         32'd0,         32'd5,         1, 0);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 0);
        // Start while busy is ignored; a normal op follows a special one back-to-back
        run_op("mulpoke", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5);
        // Start in the DONE cycle: second op again reports done 34 cycles later
        run_op("b2b",    3'b101, 32'd1000,      32'd10,        32'd100,       34, 0);

        // Reset pulse in the middle of a divide
        funct3 = 3'b100;
        dataa  = 32'hFFFF_FFF9;
        datab  = 32'h0000_0002;
        start  = 1'b1;
        c10 = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            c10 = c;
        end
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        check("pre_rst_cycle", 32'(c10), 32'd10);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_result", result, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("postrst_done", {31'b0, done}, 32'd0);
        run_op("divu93", 3'b101, 32'd9, 32'd3, 32'd3, 34, 0);
        @(negedge clock);
        check("final_idle_done", {31'b0, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
